// File: rtl/regfile_sequencer_if.sv
// rtl/regfile_sequencer_if.sv - instruction, register-file strobe and memory handshake bundle
interface regfile_sequencer_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  op;
  logic [4:0]  rs1_in;
  logic [4:0]  rs2_in;
  logic [4:0]  rd_in;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        wr1;
  logic        wr2;
  logic        store;
  logic        wr_en;
  logic        load;
  logic        alu_start;
  logic        alu_done;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ack;
  logic        busy;
  logic        illegal;
  logic        timeout;
  logic        retire;
  logic [15:0] retire_count;

  modport master (
    output instr_valid, op, rs1_in, rs2_in, rd_in, alu_done, mem_ack,
    input  instr_ready, rs1, rs2, rd, wr1, wr2, store, wr_en, load, alu_start,
           mem_req, mem_we, busy, illegal, timeout, retire, retire_count
  );

  modport slave (
    input  instr_valid, op, rs1_in, rs2_in, rd_in, alu_done, mem_ack,
    output instr_ready, rs1, rs2, rd, wr1, wr2, store, wr_en, load, alu_start,
           mem_req, mem_we, busy, illegal, timeout, retire, retire_count
  );
endinterface

// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - per-instruction register-file / ALU / memory sequencer
module regfile_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  regfile_sequencer_if.slave  bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_STORE_RD, S_EXEC, S_MEM, S_WB
  } state_t;

  localparam logic [2:0] OP_R     = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd2;
  localparam logic [2:0] OP_STORE = 3'd3;
  localparam logic [2:0] OP_UPPER = 3'd4;
  localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_op;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [4:0]  r_rd;
  logic [7:0]  r_mem_cnt;
  logic        r_exec_first;
  logic        r_illegal;
  logic        r_timeout;
  logic        r_retire;
  logic [15:0] r_retire_count;
  logic        w_accept;
  logic        w_reject;
  logic        w_mem_expire;
  logic        w_retire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    w_reject      = 1'b0;
    w_mem_expire  = 1'b0;
    w_retire      = 1'b0;
    bus.instr_ready = 1'b0;
    bus.wr1       = 1'b0;
    bus.wr2       = 1'b0;
    bus.store     = 1'b0;
    bus.wr_en     = 1'b0;
    bus.load      = 1'b0;
    bus.alu_start = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) begin
          if (bus.op <= OP_UPPER) begin
            w_accept = 1'b1;
            w_next   = (bus.op == OP_UPPER) ? S_WB : S_READ;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_READ: begin
        bus.wr1 = 1'b1;
        bus.wr2 = (r_op == OP_R);
        if (r_op == OP_LOAD)       w_next = S_MEM;
        else if (r_op == OP_STORE) w_next = S_STORE_RD;
        else                       w_next = S_EXEC;
      end
      S_STORE_RD: begin
        bus.store = 1'b1;
        w_next    = S_MEM;
      end
      S_EXEC: begin
        bus.alu_start = r_exec_first;
        if (bus.alu_done) w_next = S_WB;
      end
      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = (r_op == OP_STORE);
        // An ack arriving on the expiry cycle still completes the access.
        if (bus.mem_ack) begin
          if (r_op == OP_STORE) begin
            w_next   = S_IDLE;
            w_retire = 1'b1;
          end else begin
            w_next = S_WB;
          end
        end else if (r_mem_cnt + 8'd1 == TIMEOUT_LIM) begin
          w_next       = S_IDLE;
          w_mem_expire = 1'b1;
        end
      end
      S_WB: begin
        bus.wr_en = (r_rd != 5'd0);
        bus.load  = (r_op == OP_LOAD);
        w_next    = S_IDLE;
        w_retire  = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op           <= 3'd0;
      r_rs1          <= 5'd0;
      r_rs2          <= 5'd0;
      r_rd           <= 5'd0;
      r_mem_cnt      <= 8'd0;
      r_exec_first   <= 1'b0;
      r_illegal      <= 1'b0;
      r_timeout      <= 1'b0;
      r_retire       <= 1'b0;
      r_retire_count <= 16'd0;
    end else begin
      if (w_accept) begin
        r_op  <= bus.op;
        r_rs1 <= bus.rs1_in;
        r_rs2 <= bus.rs2_in;
        r_rd  <= bus.rd_in;
      end
      if (w_next == S_MEM && r_state != S_MEM)
        r_mem_cnt <= 8'd0;
      else if (r_state == S_MEM && !bus.mem_ack)
        r_mem_cnt <= r_mem_cnt + 8'd1;
      r_exec_first <= (w_next == S_EXEC) && (r_state != S_EXEC);
      r_illegal    <= w_reject;
      r_timeout    <= w_mem_expire;
      r_retire     <= w_retire;
      if (w_retire) r_retire_count <= r_retire_count + 16'd1;
    end
  end

  assign bus.rs1          = r_rs1;
  assign bus.rs2          = r_rs2;
  assign bus.rd           = r_rd;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.illegal      = r_illegal;
  assign bus.timeout      = r_timeout;
  assign bus.retire       = r_retire;
  assign bus.retire_count = r_retire_count;
endmodule

// File: tb/tb_regfile_sequencer.sv
// tb/tb_regfile_sequencer.sv - directed self-checking bench for regfile_sequencer
module tb_regfile_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  regfile_sequencer_if bus();

  regfile_sequencer #(.MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d);
    bus.instr_valid = 1'b1;
    bus.op     = op;
    bus.rs1_in = a;
    bus.rs2_in = b;
    bus.rd_in  = d;
    step();
    bus.instr_valid = 1'b0;
    bus.rs1_in = 5'd0;
    bus.rs2_in = 5'd0;
    bus.rd_in  = 5'd0;
  endtask

  initial begin
    reset           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.op          = 3'd0;
    bus.rs1_in      = 5'd0;
    bus.rs2_in      = 5'd0;
    bus.rd_in       = 5'd0;
    bus.alu_done    = 1'b0;
    bus.mem_ack     = 1'b0;
    step();
    step();
    check("rst_ready", bus.instr_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_rd", bus.rd, 0);
    check("rst_count", bus.retire_count, 0);
    check("rst_strobes", {bus.wr1, bus.wr2, bus.store, bus.wr_en, bus.load,
                          bus.alu_start, bus.mem_req, bus.mem_we}, 0);
    reset = 1'b1;

    // R-type, alu_done on third EXEC cycle
    offer(3'd0, 5'd3, 5'd4, 5'd5);
    check("r_read_wr", {bus.wr1, bus.wr2}, 2'b11);
    check("r_read_idx", {bus.rs1, bus.rs2, bus.rd}, {5'd3, 5'd4, 5'd5});
    check("r_busy", {bus.busy, bus.instr_ready}, 2'b10);
    step();
    check("r_exec1_start", bus.alu_start, 1);
    check("r_exec1_wr", {bus.wr1, bus.wr2}, 0);
    step();
    check("r_exec2_start", bus.alu_start, 0);
    step();
    bus.alu_done = 1'b1;
    check("r_exec3_start", bus.alu_start, 0);
    step();
    bus.alu_done = 1'b0;
    check("r_wb", {bus.wr_en, bus.load, bus.wr1, bus.wr2}, 4'b1000);
    check("r_wb_rd", bus.rd, 5);
    step();
    check("r_retire", bus.retire, 1);
    check("r_count", bus.retire_count, 1);
    check("r_ready", bus.instr_ready, 1);
    step();
    check("r_retire_once", bus.retire, 0);

    // LOAD to x0, ack on second MEM cycle
    offer(3'd2, 5'd1, 5'd2, 5'd0);
    check("ld_read_wr", {bus.wr1, bus.wr2}, 2'b10);
    step();
    check("ld_mem1", {bus.mem_req, bus.mem_we}, 2'b10);
    step();
    bus.mem_ack = 1'b1;
    check("ld_mem2", {bus.mem_req, bus.mem_we}, 2'b10);
    step();
    bus.mem_ack = 1'b0;
    check("ld_wb", {bus.load, bus.wr_en, bus.mem_req}, 3'b100);
    step();
    check("ld_retire", bus.retire, 1);
    check("ld_count", bus.retire_count, 2);

    // STORE
    offer(3'd3, 5'd6, 5'd7, 5'd9);
    check("st_read", {bus.wr1, bus.wr2, bus.store}, 3'b100);
    step();
    check("st_storerd", {bus.wr1, bus.wr2, bus.store}, 3'b001);
    step();
    check("st_mem1", {bus.mem_req, bus.mem_we, bus.wr_en}, 3'b110);
    step();
    bus.mem_ack = 1'b1;
    check("st_mem2", {bus.mem_req, bus.mem_we, bus.wr_en}, 3'b110);
    step();
    bus.mem_ack = 1'b0;
    check("st_exit", {bus.retire, bus.mem_req, bus.wr_en, bus.busy}, 4'b1000);
    check("st_count", bus.retire_count, 3);
    check("st_rs2_hold", bus.rs2, 7);

    // LOAD timeout after 4 MEM cycles
    offer(3'd2, 5'd1, 5'd1, 5'd8);
    step();
    for (int i = 0; i < 4; i++) begin
      check("to_mem", {bus.mem_req, bus.wr_en, bus.timeout}, 3'b100);
      step();
    end
    check("to_pulse", {bus.timeout, bus.retire, bus.instr_ready, bus.wr_en}, 4'b1010);
    check("to_count", bus.retire_count, 3);
    step();
    check("to_once", bus.timeout, 0);

    // LOAD with ack exactly on the 4th MEM cycle
    offer(3'd2, 5'd1, 5'd1, 5'd8);
    step();
    for (int i = 0; i < 3; i++) step();
    bus.mem_ack = 1'b1;
    check("ack4_mem", bus.mem_req, 1);
    step();
    bus.mem_ack = 1'b0;
    check("ack4_wb", {bus.timeout, bus.load, bus.wr_en}, 3'b011);
    step();
    check("ack4_retire", bus.retire, 1);
    check("ack4_count", bus.retire_count, 4);

    // illegal opcode
    offer(3'd5, 5'd31, 5'd30, 5'd29);
    check("ill_pulse", {bus.illegal, bus.instr_ready, bus.busy}, 3'b110);
    check("ill_idx", {bus.rs1, bus.rs2, bus.rd}, {5'd1, 5'd1, 5'd8});
    step();
    check("ill_once", bus.illegal, 0);

    // reset during the second EXEC cycle
    offer(3'd1, 5'd2, 5'd2, 5'd10);
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst", {bus.busy, bus.instr_ready, bus.alu_start, bus.wr1}, 4'b0100);
    check("mid_rst_rd", bus.rd, 0);
    check("mid_rst_count", bus.retire_count, 0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst", {bus.retire, bus.busy, bus.wr_en, bus.illegal, bus.timeout}, 0);
    end

    // counter wrap
    force dut.r_retire_count = 16'hFFFF;
    #1;
    release dut.r_retire_count;
    check("wrap_preset", bus.retire_count, 16'hFFFF);
    offer(3'd4, 5'd0, 5'd0, 5'd3);
    check("up_wb", {bus.wr_en, bus.load, bus.wr1, bus.rd}, {3'b100, 5'd3});
    step();
    check("wrap_retire", bus.retire, 1);
    check("wrap_count", bus.retire_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
